// File: rtl/mag_cmp_pkg.sv
// mag_cmp_pkg
// Shared definitions for the sequential magnitude comparator:
//   - state_t   : FSM state encoding (IDLE, SCAN, DONE)
//   - calc_ndig : number of DIGIT-bit slices in a WIDTH-bit operand
//   - calc_idx_w: width of the slice index (at least 1 bit)
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-slice operand still needs a 1-bit index so the register exists.
    function automatic int calc_idx_w(input int width, input int digit);
        int ndig;
        ndig = width / digit;
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// cmp_digit
// Purely combinational comparison of one DIGIT-bit slice.
// Ports:
//   a, b   : slice operands (DIGIT bits, unsigned)
//   gt     : a > b
//   lt     : a < b
//   eq     : a == b
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/mag_cmp_seq.sv
// mag_cmp_seq
// Sequential magnitude comparator. Operands are accepted over a valid/ready
// handshake, compared MSB-first one DIGIT-bit slice per clock with early exit
// at the first differing slice, and a one-hot greater/lesser/equal result is
// returned over a second valid/ready handshake.
// Optional feature macro: SIGNED_CMP_EN (adds signed_mode, two's-complement
// ordering by inverting the sign bit of both captured operands).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b [, signed_mode])
//   a, b                  : WIDTH-bit operands
//   signed_mode           : compare as two's complement (SIGNED_CMP_EN only)
//   out_valid / out_ready : result handshake
//   greater, lesser, equal: registered one-hot result flags
// WIDTH must be an integer multiple of DIGIT.
module mag_cmp_seq
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int IDX_W = calc_idx_w(WIDTH, DIGIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             greater_reg, greater_next;
    logic             lesser_reg, lesser_next;
    logic             equal_reg, equal_next;

    logic [WIDTH-1:0] a_cmp, b_cmp;
    logic [DIGIT-1:0] slice_a [NDIG];
    logic [DIGIT-1:0] slice_b [NDIG];
    logic [DIGIT-1:0] sel_a, sel_b;
    logic             dig_gt, dig_lt, dig_eq;

`ifdef SIGNED_CMP_EN
    logic signed_reg, signed_next;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the slice datapath stays unchanged.
    assign a_cmp = {a_reg[WIDTH-1] ^ signed_reg, a_reg[WIDTH-2:0]};
    assign b_cmp = {b_reg[WIDTH-1] ^ signed_reg, b_reg[WIDTH-2:0]};
`else
    assign a_cmp = a_reg;
    assign b_cmp = b_reg;
`endif

    // Slice 0 is the MSB slice.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_slice
            assign slice_a[gi] = a_cmp[WIDTH-1-gi*DIGIT -: DIGIT];
            assign slice_b[gi] = b_cmp[WIDTH-1-gi*DIGIT -: DIGIT];
        end
    endgenerate

    assign sel_a = slice_a[idx_reg];
    assign sel_b = slice_b[idx_reg];

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_cmp_digit (
        .a  (sel_a),
        .b  (sel_b),
        .gt (dig_gt),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    // in_ready is held low during reset even though the state is already IDLE.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign greater   = greater_reg;
    assign lesser    = lesser_reg;
    assign equal     = equal_reg;

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        idx_next     = idx_reg;
        greater_next = greater_reg;
        lesser_next  = lesser_reg;
        equal_next   = equal_reg;
`ifdef SIGNED_CMP_EN
        signed_next  = signed_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    idx_next   = '0;
`ifdef SIGNED_CMP_EN
                    signed_next = signed_mode;
`endif
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (dig_gt) begin
                    greater_next = 1'b1;
                    state_next   = DONE;
                end else if (dig_lt) begin
                    lesser_next = 1'b1;
                    state_next  = DONE;
                end else if (dig_eq && (idx_reg == LAST_IDX)) begin
                    equal_next = 1'b1;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    greater_next = 1'b0;
                    lesser_next  = 1'b0;
                    equal_next   = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            idx_reg     <= '0;
            greater_reg <= 1'b0;
            lesser_reg  <= 1'b0;
            equal_reg   <= 1'b0;
`ifdef SIGNED_CMP_EN
            signed_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            idx_reg     <= idx_next;
            greater_reg <= greater_next;
            lesser_reg  <= lesser_next;
            equal_reg   <= equal_next;
`ifdef SIGNED_CMP_EN
            signed_reg  <= signed_next;
`endif
        end
    end

endmodule
